// File: rtl/adia_pkg.sv
// Shared types for the adiabatic injection bridge: Gray-coded power-clock phase states.
package adia_pkg;

  typedef enum logic [1:0] {
    PHI_LOW  = 2'b00,
    PHI_RISE = 2'b01,
    PHI_HIGH = 2'b11,
    PHI_FALL = 2'b10
  } phi_e;

  localparam int ADIA_NSTATE = 4;

  // Step index (LOW, RISE, HIGH, FALL order) to Gray-coded phase state.
  function automatic phi_e step2phi(input logic [1:0] s);
    case (s)
      2'd0:    return PHI_LOW;
      2'd1:    return PHI_RISE;
      2'd2:    return PHI_HIGH;
      default: return PHI_FALL;
    endcase
  endfunction

endpackage

// File: rtl/adia_phase_gen.sv
// Trapezoidal power-clock sequencer: tick/step counters, run gating at state
// boundaries, staggered phase fan-out, and load/clear strobes for phase 0.
module adia_phase_gen
  import adia_pkg::*;
#(
  parameter int NPHASE   = 4,
  parameter int RAMP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [2*NPHASE-1:0] phi_state,
  output logic                load_pulse,
  output logic                clear_pulse
);

  localparam int TICK_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        step_q, step_d;
  logic [1:0]        warm_q, warm_d;
  logic              rollover;
  logic              advance;

  always_comb begin
    rollover    = (tick_q == TICK_W'(RAMP_CYC - 1));
    advance     = rollover && run;
    tick_d      = tick_q;
    step_d      = step_q;
    warm_d      = warm_q;
    load_pulse  = advance && (step_q == 2'd0);
    clear_pulse = advance && (step_q == 2'd3);
    // run is only honoured at a boundary, so a ramp already started always completes.
    if (advance) begin
      tick_d = '0;
      step_d = 2'((int'(step_q) + 1) % ADIA_NSTATE);
      if (warm_q != 2'(NPHASE - 1))
        warm_d = warm_q + 2'd1;
    end else if (!rollover) begin
      tick_d = tick_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      step_q <= '0;
      warm_q <= '0;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
      warm_q <= warm_d;
    end
  end

  // Phase k stays LOW after reset until the sequence has advanced k steps,
  // so every lagging phase starts its first cycle from LOW.
  always_comb begin
    phi_state = '0;
    for (int k = 0; k < NPHASE; k++) begin
      if (2'(k) <= warm_q)
        phi_state[2*k +: 2] = step2phi(step_q - 2'(k));
      else
        phi_state[2*k +: 2] = PHI_LOW;
    end
  end

endmodule

// File: rtl/adia_inject_bridge.sv
// Static-to-adiabatic injection bridge: input FIFO, phase-0 hold register and
// injection counter around the power-clock sequencer.
module adia_inject_bridge
  import adia_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NPHASE    = 4,
  parameter int RAMP_CYC  = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                adia_valid,
  output logic [WIDTH-1:0]    adia_data,
  output logic [2*NPHASE-1:0] phi_state,
  output logic [15:0]         inj_count,
  output logic                busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic             load_pulse;
  logic             clear_pulse;

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             adia_valid_q, adia_valid_d;
  logic [WIDTH-1:0] adia_data_q, adia_data_d;
  logic [15:0]      inj_count_q, inj_count_d;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  adia_phase_gen #(
    .NPHASE   (NPHASE),
    .RAMP_CYC (RAMP_CYC)
  ) u_phase_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .phi_state   (phi_state),
    .load_pulse  (load_pulse),
    .clear_pulse (clear_pulse)
  );

  // in_ready is a register, so a push while full is never accepted.
  assign push = in_valid && in_ready_q;
  assign pop  = load_pulse && (cnt_q != '0);

  always_comb begin
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d        = cnt_q;
    adia_valid_d = adia_valid_q;
    adia_data_d  = adia_data_q;
    inj_count_d  = inj_count_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CNT_W'(1);
    // An empty buffer at the load edge injects a zero-swing bubble.
    if (load_pulse) begin
      adia_valid_d = pop;
      adia_data_d  = pop ? mem_q[rd_ptr_q] : '0;
      if (pop)
        inj_count_d = inj_count_q + 16'd1;
    end else if (clear_pulse) begin
      adia_valid_d = 1'b0;
      adia_data_d  = '0;
    end
    in_ready_d = (cnt_d != CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      adia_valid_q <= 1'b0;
      adia_data_q  <= '0;
      inj_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      adia_valid_q <= adia_valid_d;
      adia_data_q  <= adia_data_d;
      inj_count_q  <= inj_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready   = in_ready_q;
  assign adia_valid = adia_valid_q;
  assign adia_data  = adia_data_q;
  assign inj_count  = inj_count_q;
  assign busy       = (cnt_q != '0) || adia_valid_q;

endmodule
